punc_control: RTL

Finite-state controller for the PUnC LC3 processor. It sits directly upstream of the PUnC datapath and drives every datapath control input each cycle. Its decisions depend only on its own state and the pc/ir values fed back from the datapath. It sequences fetch/decode/execute for the LC3 subset ADD, AND, NOT, BR, JMP/RET, JSR/JSRR, LD, LDI, LDR, LEA, ST, STI, STR and HALT (TRAP x25).

---
 rtl/punc_control_pkg.sv | 58 +++++
 rtl/punc_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC LC3 controller: opcodes, ALU codes,
// datapath mux selects and controller state encoding.
package punc_control_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_ADDI    = 5'd1;
  localparam logic [4:0] ALU_AND     = 5'd2;
  localparam logic [4:0] ALU_ANDI    = 5'd3;
  localparam logic [4:0] ALU_NOT     = 5'd4;
  localparam logic [4:0] ALU_BR      = 5'd5;
  localparam logic [4:0] ALU_JMP_RET = 5'd6;
  localparam logic [4:0] ALU_JSR     = 5'd7;
  localparam logic [4:0] ALU_JSRR    = 5'd8;
  localparam logic [4:0] ALU_LD      = 5'd9;
  localparam logic [4:0] ALU_LDR     = 5'd10;
  localparam logic [4:0] ALU_LEA     = 5'd11;
  localparam logic [4:0] ALU_LDI1    = 5'd12;
  localparam logic [4:0] ALU_LDI2    = 5'd13;
  localparam logic [4:0] ALU_ST      = 5'd14;
  localparam logic [4:0] ALU_STR     = 5'd15;
  localparam logic [4:0] ALU_STI1    = 5'd16;

  localparam logic [1:0] MEM_R_ALU       = 2'd0;
  localparam logic [1:0] MEM_R_CTRL      = 2'd1;
  localparam logic [1:0] MEM_W_ADDR_ALU  = 2'd0;
  localparam logic [1:0] MEM_W_ADDR_SELF = 2'd1;
  localparam logic [1:0] MEM_W_DATA_R0   = 2'd0;
  localparam logic [1:0] MEM_W_DATA_R1   = 2'd1;

  localparam logic [1:0] RF_W_ALU   = 2'd0;
  localparam logic [1:0] RF_W_CNTRL = 2'd1;
  localparam logic [1:0] RF_W_PC    = 2'd2;
  localparam logic [1:0] RF_W_MEM   = 2'd3;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_EXEC2  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 controller: fetch/decode/execute sequencer driving every
// datapath control input from its state and the fed-back IR/PC.
module punc_control
  import punc_control_pkg::*;
#(
  parameter int         WORD_W        = 16,
  parameter logic [7:0] HALT_TRAPVECT = 8'h25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] ir,
  output logic              pc_inc,
  output logic              pc_clr,
  output logic              pc_w_en,
  output logic              ir_w_en,
  output logic [WORD_W-1:0] mem_r_addr_ctrl,
  output logic [1:0]        mem_r_s,
  output logic [1:0]        mem_w_addr_s,
  output logic [1:0]        mem_w_data_s,
  output logic              mem_w_en,
  output logic [4:0]        alu_s,
  output logic              rf_w_en,
  output logic [1:0]        rf_w_s,
  output logic [2:0]        rf_w_addr,
  output logic [WORD_W-1:0] rf_w_data_ctrl,
  output logic [2:0]        rf_r0_addr,
  output logic [2:0]        rf_r1_addr,
  output logic              status_w_en,
  output logic              halted
);

  logic [2:0] state_q, state_d;
  logic [3:0] op;
  logic [2:0] dr, sr1, sr2;

  assign op  = ir[15:12];
  assign dr  = ir[11:9];
  assign sr1 = ir[8:6];
  assign sr2 = ir[2:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_TRAP)
          state_d = (ir[7:0] == HALT_TRAPVECT) ? ST_HALT : ST_FETCH;
        else if (op == OP_RTI || op == OP_RES)
          state_d = ST_FETCH;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = (op == OP_LDI) ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Reset overrides decode so an abandoned instruction never writes.
  always_comb begin
    pc_inc          = 1'b0;
    pc_clr          = 1'b0;
    pc_w_en         = 1'b0;
    ir_w_en         = 1'b0;
    mem_r_addr_ctrl = '0;
    mem_r_s         = MEM_R_ALU;
    mem_w_addr_s    = MEM_W_ADDR_ALU;
    mem_w_data_s    = MEM_W_DATA_R0;
    mem_w_en        = 1'b0;
    alu_s           = ALU_ADD;
    rf_w_en         = 1'b0;
    rf_w_s          = RF_W_ALU;
    rf_w_addr       = 3'd0;
    rf_w_data_ctrl  = '0;
    rf_r0_addr      = 3'd0;
    rf_r1_addr      = 3'd0;
    status_w_en     = 1'b0;
    halted          = 1'b0;
    if (rst) begin
      pc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_r_s         = MEM_R_CTRL;
          mem_r_addr_ctrl = pc;
          ir_w_en         = 1'b1;
          pc_inc          = 1'b1;
        end
        ST_EXEC: begin
          case (op)
            OP_ADD, OP_AND: begin
              if (op == OP_ADD) alu_s = ir[5] ? ALU_ADDI : ALU_ADD;
              else              alu_s = ir[5] ? ALU_ANDI : ALU_AND;
              rf_r0_addr  = sr1;
              rf_r1_addr  = sr2;
              rf_w_s      = RF_W_ALU;
              rf_w_addr   = dr;
              rf_w_en     = 1'b1;
              status_w_en = 1'b1;
            end
            OP_NOT: begin
              alu_s       = ALU_NOT;
              rf_r0_addr  = sr1;
              rf_w_s      = RF_W_ALU;
              rf_w_addr   = dr;
              rf_w_en     = 1'b1;
              status_w_en = 1'b1;
            end
            OP_BR: begin
              alu_s   = ALU_BR;
              pc_w_en = 1'b1;
            end
            OP_JMP: begin
              alu_s      = ALU_JMP_RET;
              rf_r0_addr = sr1;
              pc_w_en    = 1'b1;
            end
            OP_JSR: begin
              // Link and jump share a cycle so R7 captures the pre-update PC.
              alu_s      = ir[11] ? ALU_JSR : ALU_JSRR;
              rf_r0_addr = ir[11] ? 3'd0 : sr1;
              rf_w_s     = RF_W_PC;
              rf_w_addr  = 3'd7;
              rf_w_en    = 1'b1;
              pc_w_en    = 1'b1;
            end
            OP_LD, OP_LDR: begin
              alu_s       = (op == OP_LD) ? ALU_LD : ALU_LDR;
              rf_r0_addr  = (op == OP_LD) ? 3'd0 : sr1;
              mem_r_s     = MEM_R_ALU;
              rf_w_s      = RF_W_MEM;
              rf_w_addr   = dr;
              rf_w_en     = 1'b1;
              status_w_en = 1'b1;
            end
            OP_LEA: begin
              alu_s       = ALU_LEA;
              rf_w_s      = RF_W_ALU;
              rf_w_addr   = dr;
              rf_w_en     = 1'b1;
              status_w_en = 1'b1;
            end
            OP_LDI: begin
              // Pointer parks in DR; flags wait for the final value.
              alu_s     = ALU_LDI1;
              mem_r_s   = MEM_R_ALU;
              rf_w_s    = RF_W_MEM;
              rf_w_addr = dr;
              rf_w_en   = 1'b1;
            end
            OP_ST: begin
              alu_s        = ALU_ST;
              rf_r0_addr   = dr;
              mem_w_addr_s = MEM_W_ADDR_ALU;
              mem_w_data_s = MEM_W_DATA_R0;
              mem_w_en     = 1'b1;
            end
            OP_STR: begin
              alu_s        = ALU_STR;
              rf_r0_addr   = dr;
              rf_r1_addr   = sr1;
              mem_w_addr_s = MEM_W_ADDR_ALU;
              mem_w_data_s = MEM_W_DATA_R0;
              mem_w_en     = 1'b1;
            end
            OP_STI: begin
              alu_s        = ALU_STI1;
              rf_r0_addr   = dr;
              mem_r_s      = MEM_R_ALU;
              mem_w_addr_s = MEM_W_ADDR_SELF;
              mem_w_data_s = MEM_W_DATA_R0;
              mem_w_en     = 1'b1;
            end
            default: ;
          endcase
        end
        ST_EXEC2: begin
          alu_s       = ALU_LDI2;
          rf_r0_addr  = dr;
          mem_r_s     = MEM_R_ALU;
          rf_w_s      = RF_W_MEM;
          rf_w_addr   = dr;
          rf_w_en     = 1'b1;
          status_w_en = 1'b1;
        end
        ST_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
